// File: rtl/seg_scan_mux.sv
// seg_scan_mux: N-digit time-multiplexed common-anode 7-segment driver with
// refresh prescaler, per-digit enable/blink and a blank interval at each slot start.
module seg_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_FRAMES = 50,
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7*NUM_DIGITS-1:0]   digits,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  output logic [6:0]                SEG,
  output logic [NUM_DIGITS-1:0]     AN,
  output logic [IW-1:0]             scan_idx,
  output logic                      frame_tick
);
  localparam int DW = $clog2(REFRESH_DIV);
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [DW-1:0]         div_q, div_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [BW-1:0]         blink_q, blink_d;
  logic                  phase_q, phase_d, slot_end, blink_wrap, active;
  logic [NUM_DIGITS-1:0] an_d;
  logic [6:0]            seg_d;
  always_comb begin
    slot_end   = div_q == DW'(REFRESH_DIV - 1);
    frame_tick = slot_end && idx_q == '0;
    blink_wrap = blink_q == BW'(BLINK_FRAMES - 1);
    div_d      = slot_end ? '0 : div_q + 1'b1;
    idx_d      = !slot_end ? idx_q : idx_q == '0 ? IW'(NUM_DIGITS - 1) : idx_q - 1'b1;
    blink_d    = !frame_tick ? blink_q : blink_wrap ? '0 : blink_q + 1'b1;
    phase_d    = phase_q ^ (frame_tick && blink_wrap);
    // signed compare keeps BLANK_CYCLES=0 from becoming a constant-true unsigned test
    active     = int'(div_q) >= BLANK_CYCLES && digit_en[idx_q] && !(phase_q && blink_mask[idx_q]);
    an_d       = active ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    seg_d      = active ? digits[7*int'(idx_q) +: 7] : 7'h7F;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= '0;
      idx_q   <= IW'(NUM_DIGITS - 1);
      blink_q <= '0;
      phase_q <= 1'b0;
      AN      <= '1;
      SEG     <= 7'h7F;
    end else begin
      div_q   <= div_d;
      idx_q   <= idx_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      AN      <= an_d;
      SEG     <= seg_d;
    end
  end
  assign scan_idx = idx_q;
endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: scoreboard bench for two seg_scan_mux configurations driven in lockstep;
// expectations come from a closed-form model indexed by cycles since reset.
module tb_seg_scan_mux;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic [27:0] dig_a;
  logic [3:0]  en_a, bm_a, an_a;
  logic [6:0]  seg_a, seg_b;
  logic [1:0]  idx_a;
  logic        ft_a, ft_b;
  logic [55:0] dig_b;
  logic [7:0]  en_b, bm_b, an_b;
  logic [2:0]  idx_b;
  seg_scan_mux #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .BLINK_FRAMES(3)) dut_a (
    .clk(clk), .reset(reset), .digits(dig_a), .digit_en(en_a), .blink_mask(bm_a),
    .SEG(seg_a), .AN(an_a), .scan_idx(idx_a), .frame_tick(ft_a));
  seg_scan_mux #(.NUM_DIGITS(8), .REFRESH_DIV(2), .BLANK_CYCLES(0), .BLINK_FRAMES(1)) dut_b (
    .clk(clk), .reset(reset), .digits(dig_b), .digit_en(en_b), .blink_mask(bm_b),
    .SEG(seg_b), .AN(an_b), .scan_idx(idx_b), .frame_tick(ft_b));
  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic [2:0] idx;
    logic       ft;
  } exp_t;
  exp_t qa[$], qb[$];
  int tests = 0, fails = 0, t = 0, fta = 0, ftb = 0;
  // output after the next edge, given the state t cycles past reset and the current inputs
  function automatic exp_t model(int tm, int n, int rd, int bl, int bf, logic [55:0] dg,
                                 logic [7:0] en, logic [7:0] bm, logic rst);
    exp_t e;
    int ix, t1, nx;
    logic act;
    ix  = n - 1 - (tm / rd) % n;
    act = (tm % rd >= bl) && en[ix] && !(((tm / (n * rd)) / bf) % 2 == 1 && bm[ix]);
    e.an  = 8'hFF;
    e.seg = 7'h7F;
    if (!rst && act) begin
      e.an[ix] = 1'b0;
      e.seg    = dg[7*ix +: 7];
    end
    t1 = rst ? 0 : tm + 1;
    nx = n - 1 - (t1 / rd) % n;
    e.idx = 3'(nx);
    e.ft  = (t1 % rd == rd - 1) && nx == 0;
    return e;
  endfunction
  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask
  task automatic step();
    exp_t e;
    qa.push_back(model(t, 4, 8, 2, 3, {28'h0, dig_a}, {4'h0, en_a}, {4'h0, bm_a}, reset));
    qb.push_back(model(t, 8, 2, 0, 1, dig_b, en_b, bm_b, reset));
    t = reset ? 0 : t + 1;
    @(posedge clk);
    #1;
    e = qa.pop_front();
    check("a_an", {4'hF, an_a}, {4'hF, e.an[3:0]});
    check("a_seg", {1'b0, seg_a}, {1'b0, e.seg});
    check("a_idx", 8'(idx_a), 8'(e.idx));
    check("a_ft", 8'(ft_a), 8'(e.ft));
    check("a_onehot", 8'($countones(~an_a) <= 1), 8'd1);
    e = qb.pop_front();
    check("b_an", an_b, e.an);
    check("b_seg", {1'b0, seg_b}, {1'b0, e.seg});
    check("b_idx", 8'(idx_b), 8'(e.idx));
    check("b_ft", 8'(ft_b), 8'(e.ft));
    check("b_onehot", 8'($countones(~an_b) <= 1), 8'd1);
    fta += int'(ft_a);
    ftb += int'(ft_b);
  endtask
  initial begin
    dig_a = {7'h40, 7'h79, 7'h24, 7'h30};
    en_a  = 4'hF;
    bm_a  = 4'h0;
    dig_b = {7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40, 7'h3F};
    en_b  = 8'hFF;
    bm_b  = 8'h00;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    fta = 0;
    ftb = 0;
    repeat (64) step();
    check("a_ft_count", 8'(fta), 8'd2);
    check("b_ft_count", 8'(ftb), 8'd4);
    en_a = 4'b1011;
    repeat (32) step();
    en_a = 4'hF;
    bm_a = 4'b0001;
    while (t < 100) step();
    dig_a[6:0] = 7'h12;
    while (t < 230) step();
    en_b = 8'b1110_1111;
    repeat (8) step();
    en_b = 8'hFF;
    while (t < 309) step();
    check("a_pre_reset_idx", 8'(idx_a), 8'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (40) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
